// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder slice.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

  localparam int unsigned SPI_DATA_WIDTH  = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;
  localparam logic        CS_IDLE         = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer with a selectable synchronous reset level.
module spi_sync #(
  parameter int unsigned N       = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= {N{RST_VAL}};
    else       r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/spi_slave.sv
// SPI responder, oversampled on the system clock; LSB-first frames by default,
// MSB-first in both directions when SPI_SLAVE_MSB_FIRST_EN is defined.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] slaveDataToSend,
  input  logic                  txLoad,
  output logic [DATA_WIDTH-1:0] slaveDataReceived,
  output logic                  rxValid,
  output logic                  busy,
  output logic                  frameError
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
`ifdef SPI_SLAVE_MSB_FIRST_EN
  localparam int unsigned PRE_IDX  = DATA_WIDTH - 1;
  localparam int unsigned NEXT_IDX = DATA_WIDTH - 2;
`else
  localparam int unsigned PRE_IDX  = 0;
  localparam int unsigned NEXT_IDX = 1;
`endif

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic r_sclk_prev, r_cs_prev;
  logic w_sclk_fall, w_cs_fall, w_cs_rise, w_last;

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0))
    u_sync_sclk (.clk(clk), .reset(reset), .i_d(SCLK), .o_q(w_sclk_s));
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(CS_IDLE))
    u_sync_cs   (.clk(clk), .reset(reset), .i_d(CS_n), .o_q(w_cs_s));
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0))
    u_sync_mosi (.clk(clk), .reset(reset), .i_d(MOSI), .o_q(w_mosi_s));

  spi_state_t            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_tx_hold, w_tx_hold_nxt;
  logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt, w_rx_shifted;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic                  r_miso, w_miso_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_frame_err, w_frame_err_nxt;

  assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;
  assign w_cs_fall   = r_cs_prev & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_prev & w_cs_s;
  assign w_last      = w_sclk_fall && (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));

`ifdef SPI_SLAVE_MSB_FIRST_EN
  assign w_rx_shifted = {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
`else
  assign w_rx_shifted = {w_mosi_s, r_rx_shift[DATA_WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= CS_IDLE;
      r_state     <= IDLE;
      r_tx_hold   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_data      <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
      r_state     <= w_state_nxt;
      r_tx_hold   <= w_tx_hold_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_data      <= w_data_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_miso      <= w_miso_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tx_hold_nxt   = txLoad ? slaveDataToSend : r_tx_hold;
    w_tx_shift_nxt  = r_tx_shift;
    w_rx_shift_nxt  = r_rx_shift;
    w_data_nxt      = r_data;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_miso_nxt      = r_miso;
    w_rx_valid_nxt  = 1'b0;
    w_busy_nxt      = r_busy;
    w_frame_err_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_miso_nxt = r_tx_hold[PRE_IDX];
        if (w_cs_fall) begin
          w_tx_shift_nxt = r_tx_hold;
          w_rx_shift_nxt = '0;
          w_bit_cnt_nxt  = '0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        if (w_sclk_fall) begin
          w_rx_shift_nxt = w_rx_shifted;
`ifdef SPI_SLAVE_MSB_FIRST_EN
          w_tx_shift_nxt = r_tx_shift << 1;
`else
          w_tx_shift_nxt = r_tx_shift >> 1;
`endif
          w_miso_nxt     = r_tx_shift[NEXT_IDX];
          w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
        end
        if (w_last) begin
          w_data_nxt     = w_rx_shifted;
          w_rx_valid_nxt = 1'b1;
          w_state_nxt    = DONE;
        end
        // CS rise wins over a simultaneous SCLK fall unless that fall was the last bit.
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          if (!w_last) w_frame_err_nxt = 1'b1;
        end
      end
      DONE: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign MISO              = r_miso;
  assign slaveDataReceived = r_data;
  assign rxValid           = r_rx_valid;
  assign busy              = r_busy;
  assign frameError        = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bit-banged master plus a byte-level reference model.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       SCLK, CS_n, MOSI, MISO;
  logic [7:0] slaveDataToSend;
  logic       txLoad;
  logic [7:0] slaveDataReceived;
  logic       rxValid, busy, frameError;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [7:0] model_hold;
  logic [7:0] rxq[$];
  int unsigned rx_pulses = 0;
  int unsigned fe_pulses = 0;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS_n(CS_n), .MOSI(MOSI), .MISO(MISO),
    .slaveDataToSend(slaveDataToSend), .txLoad(txLoad),
    .slaveDataReceived(slaveDataReceived), .rxValid(rxValid), .busy(busy),
    .frameError(frameError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rxValid) begin
      rx_pulses++;
      rxq.push_back(slaveDataReceived);
    end
    if (frameError) fe_pulses++;
  end

  // Wire position of serial bit i within the byte.
  function automatic int unsigned bpos(input int unsigned i);
`ifdef SPI_SLAVE_MSB_FIRST_EN
    return 7 - i;
`else
    return i;
`endif
  endfunction

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    slaveDataToSend = v;
    txLoad = 1'b1;
    model_hold = v;
    @(negedge clk);
    txLoad = 1'b0;
  endtask

  // Master: CS low, nbits SCLK pulses at clk/8, MOSI changed after rise, MISO sampled at fall.
  task automatic frame(input logic [7:0] tx, input int unsigned nbits, input bit raise_cs,
                       input int load_at, input logic [7:0] load_val,
                       output logic [7:0] rx, output logic busy_mid);
    rx = '0;
    CS_n = 1'b0;
    repeat (4) @(negedge clk);
    busy_mid = busy;
    for (int unsigned i = 0; i < nbits; i++) begin
      SCLK = 1'b1;
      MOSI = (i < 8) ? tx[bpos(i)] : 1'b0;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
      if (i < 8) rx[bpos(i)] = MISO;
      if (int'(i) == load_at) begin
        slaveDataToSend = load_val;
        txLoad = 1'b1;
        model_hold = load_val;
        @(negedge clk);
        txLoad = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
    end
    if (raise_cs) begin
      CS_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if ({MISO, rxValid, busy, frameError} !== 4'b0000) begin
      $display("FAIL reset_ctrl: got MISO/rxValid/busy/frameError=%b want 0000",
               {MISO, rxValid, busy, frameError});
    end else n_pass++;
    n_total++;
    if (slaveDataReceived !== 8'h00) begin
      $display("FAIL reset_data: got %h want 00", slaveDataReceived);
    end else n_pass++;
    reset = 1'b0;
    model_hold = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp);
    logic [7:0] got;
    n_total++;
    if (rxq.size() == 0) begin
      $display("FAIL %s: no rxValid pulse, want data %h", name, exp);
    end else begin
      got = rxq.pop_front();
      if (got !== exp) $display("FAIL %s: got %h want %h", name, got, exp);
      else n_pass++;
    end
  endtask

  task automatic check_miso(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: master got %h want %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] rx, exp_tx;
    logic bm;
    int unsigned p0;
    load(8'hA5);
    exp_tx = model_hold;
    p0 = rx_pulses;
    frame(8'h3C, 8, 1'b1, -1, 8'h00, rx, bm);
    check_rx("basic_rx", 8'h3C);
    check_miso("basic_tx", rx, exp_tx);
    n_total++;
    if (rx_pulses - p0 != 1) $display("FAIL basic_pulses: got %0d want 1", rx_pulses - p0);
    else n_pass++;
    n_total++;
    if ({bm, busy} !== 2'b10) $display("FAIL basic_busy: during/after got %b want 10", {bm, busy});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx1, rx2, exp_tx;
    logic bm;
    exp_tx = model_hold;
    frame(8'h01, 8, 1'b1, -1, 8'h00, rx1, bm);
    frame(8'hFE, 8, 1'b1, -1, 8'h00, rx2, bm);
    check_rx("b2b_rx1", 8'h01);
    check_rx("b2b_rx2", 8'hFE);
    check_miso("b2b_tx1", rx1, exp_tx);
    check_miso("b2b_tx2", rx2, exp_tx);
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic bm;
    int unsigned f0, p0;
    f0 = fe_pulses;
    p0 = rx_pulses;
    frame(8'hFF, 5, 1'b1, -1, 8'h00, rx, bm);
    n_total++;
    if (fe_pulses - f0 != 1 || rx_pulses != p0)
      $display("FAIL abort_pulses: frameError=%0d rxValid=%0d want 1/0", fe_pulses - f0, rx_pulses - p0);
    else n_pass++;
    n_total++;
    if (slaveDataReceived !== 8'hFE) $display("FAIL abort_keep: got %h want FE", slaveDataReceived);
    else n_pass++;
    frame(8'h55, 8, 1'b1, -1, 8'h00, rx, bm);
    check_rx("abort_next_rx", 8'h55);
  endtask

  task automatic test_midload();
    logic [7:0] rx;
    logic bm;
    load(8'h0F);
    frame(8'h11, 8, 1'b1, 3, 8'hC3, rx, bm);
    check_miso("midload_cur", rx, 8'h0F);
    check_rx("midload_rx", 8'h11);
    frame(8'h22, 8, 1'b1, -1, 8'h00, rx, bm);
    check_miso("midload_next", rx, 8'hC3);
    check_rx("midload_rx2", 8'h22);
  endtask

  task automatic test_extra_edges();
    logic [7:0] rx, exp_tx;
    logic bm;
    int unsigned p0, f0;
    exp_tx = model_hold;
    p0 = rx_pulses;
    f0 = fe_pulses;
    frame(8'h96, 10, 1'b1, -1, 8'h00, rx, bm);
    n_total++;
    if (rx_pulses - p0 != 1 || fe_pulses != f0)
      $display("FAIL extra_pulses: rxValid=%0d frameError=%0d want 1/0", rx_pulses - p0, fe_pulses - f0);
    else n_pass++;
    check_rx("extra_rx", 8'h96);
    check_miso("extra_tx", rx, exp_tx);
  endtask

  task automatic test_random();
    logic [7:0] rx, tx, exp_tx;
    logic bm;
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(1, 0) == 1) load(8'($urandom));
      exp_tx = model_hold;
      tx = 8'($urandom);
      frame(tx, 8, 1'b1, -1, 8'h00, rx, bm);
      check_rx("rand_rx", tx);
      check_miso("rand_tx", rx, exp_tx);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    logic bm;
    int unsigned p0, f0;
    load(8'hFF);
    p0 = rx_pulses;
    f0 = fe_pulses;
    frame(8'hAA, 4, 1'b0, -1, 8'h00, rx, bm);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({MISO, busy, rxValid, frameError} !== 4'b0000 || slaveDataReceived !== 8'h00)
      $display("FAIL resetmid_out: got ctrl=%b data=%h want 0000/00",
               {MISO, busy, rxValid, frameError}, slaveDataReceived);
    else n_pass++;
    CS_n = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    model_hold = 8'h00;
    repeat (8) @(negedge clk);
    n_total++;
    if (rx_pulses != p0 || fe_pulses != f0 || busy !== 1'b0)
      $display("FAIL resetmid_pulses: rxValid=%0d frameError=%0d busy=%b want 0/0/0",
               rx_pulses - p0, fe_pulses - f0, busy);
    else n_pass++;
  endtask

  task automatic test_predrive();
    logic [7:0] v;
    load(8'h80);
    repeat (2) @(negedge clk);
    v = model_hold;
    n_total++;
    if (MISO !== v[bpos(0)]) $display("FAIL predrive: MISO got %b want %b", MISO, v[bpos(0)]);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    SCLK = 1'b0;
    CS_n = 1'b1;
    MOSI = 1'b0;
    txLoad = 1'b0;
    slaveDataToSend = '0;
    model_hold = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_midload();
    test_extra_edges();
    test_random();
    test_reset_mid();
    test_predrive();
    n_total++;
    if (rxq.size() != 0) $display("FAIL stray_rx: %0d unexpected rxValid pulses", rxq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
